note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/seq_pkg.sv | 44 ++++
 rtl/song_rom.sv | 46 ++++
 rtl/note_sequencer.sv | 141 ++++++++++++++
 tb/tb_note_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the note sequencer.
// Holds FSM states, song entry layout and buzzer codes.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;
  localparam int DUR_W  = 3;
  localparam int IDX_W  = 6;
  localparam int SONG_W = 2;
  localparam int ADDR_W = SONG_W + IDX_W;

  // {last[9], dur[8:6], oct[5:4], note[3:0]}
  typedef struct packed {
    logic              last;
    logic [DUR_W-1:0]  dur;
    logic [OCT_W-1:0]  oct;
    logic [NOTE_W-1:0] note;
  } entry_t;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;

  localparam logic [OCT_W-1:0] OCT_NORM = 2'b00;
  localparam logic [OCT_W-1:0] OCT_LOW  = 2'b01;
  localparam logic [OCT_W-1:0] OCT_HIGH = 2'b10;
  localparam logic [OCT_W-1:0] OCT_RSVD = 2'b11;

  function automatic entry_t mk(
    input logic              last,
    input logic [DUR_W-1:0]  dur,
    input logic [OCT_W-1:0]  oct,
    input logic [NOTE_W-1:0] note
  );
    return {last, dur, oct, note};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Four-song table, 64 entries each, with a registered read port.
// Song 1 is a full 64-entry loop with no last flag.
module song_rom
  import seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  output entry_t            data_o
);

  entry_t rom_d;
  entry_t data_q;

  always_comb begin
    rom_d = '0;
    case (addr_i[ADDR_W-1:IDX_W])
      2'd0: begin
        if (addr_i[IDX_W-1:0] == 6'd0)
          rom_d = mk(1'b0, 3'd1, OCT_NORM, 4'd1);
        else if (addr_i[IDX_W-1:0] == 6'd1)
          rom_d = mk(1'b1, 3'd0, OCT_HIGH, 4'd5);
      end
      2'd1: begin
        rom_d = mk(1'b0, 3'd0, {1'b0, addr_i[0]},
                   4'(addr_i[IDX_W-1:0] % 6'd7) + 4'd1);
      end
      2'd2: begin
        if (addr_i[IDX_W-1:0] == 6'd0)
          rom_d = mk(1'b1, 3'd7, OCT_RSVD, NOTE_REST);
      end
      default: begin
        if (addr_i[IDX_W-1:0] == 6'd0)
          rom_d = mk(1'b1, 3'd0, OCT_RSVD, 4'd7);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= rom_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/note_sequencer.sv
// Plays a stored song on a buzzer: note/octave per entry, then a gap.
// The ROM is addressed one entry ahead so FETCH sees data in one cycle.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SONG_W-1:0] song_sel,
  output logic [NOTE_W-1:0] note,
  output logic [OCT_W-1:0]  octave,
  output logic              busy,
  output logic              done
);

  localparam int BW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_TICKS - 1);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
  logic [BW-1:0]       beat_q, beat_d;
  logic [DUR_W-1:0]    left_q, left_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [OCT_W-1:0]    oct_q, oct_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   rom_addr;
  entry_t              rom_data;

  assign idx_nxt = idx_q + 6'd1;
  assign rom_addr = (state_q == S_IDLE) ? {song_sel, 6'd0}
                                        : {song_q, idx_nxt};

  song_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    left_d  = left_q;
    gap_d   = gap_q;
    note_d  = note_q;
    oct_d   = oct_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          song_d  = song_sel;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        note_d  = rom_data.note;
        oct_d   = (rom_data.oct == OCT_RSVD) ? OCT_NORM : rom_data.oct;
        last_d  = rom_data.last;
        left_d  = rom_data.dur;
        beat_d  = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
          if (left_q == '0) begin
            note_d  = NOTE_REST;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            left_d = left_q - 3'd1;
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (last_q) begin
            oct_d   = OCT_NORM;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_nxt;
            state_d = S_FETCH;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every in-song transition
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
      note_d  = NOTE_REST;
      oct_d   = OCT_NORM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      left_q  <= '0;
      gap_q   <= '0;
      note_q  <= NOTE_REST;
      oct_q   <= OCT_NORM;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      left_q  <= left_d;
      gap_q   <= gap_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      last_q  <= last_d;
    end
  end

  assign note   = note_q;
  assign octave = oct_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with BEAT_TICKS=4, GAP_TICKS=1.
// Expected outputs are queued per cycle and compared on the falling edge.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic [3:0] note;
  logic [1:0] octave;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  note_sequencer #(
    .BEAT_TICKS (4),
    .GAP_TICKS  (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .song_sel (song_sel),
    .note     (note),
    .octave   (octave),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;

  wire [7:0] obs = {note, octave, busy, done};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      assert (e.cyc == cyc && obs === e.v) else begin
        errors++;
        $error("FAIL %s cyc %0d (due %0d): observed %h expected %h",
               e.tag, cyc, e.cyc, obs, e.v);
      end
    end
  end

  task automatic exp_rng(input int base, input int a, input int b,
                         input logic [3:0] n, input logic [1:0] o,
                         input logic bz, input logic dn, input string tag);
    for (int k = a; k <= b; k++)
      q.push_back('{cyc: base + k, v: {n, o, bz, dn}, tag: tag});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic direct_idle(input string tag);
    checks++;
    assert (obs === 8'h00) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, 8'h00);
    end
  endtask

  initial begin
    // reset state
    #2 rst_n = 1'b0;
    #1 direct_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // song 0 full playback
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd0;
    exp_rng(c0, 1, 1, 4'd0, 2'b00, 1'b1, 1'b0, "s0_fetch");
    exp_rng(c0, 2, 9, 4'd1, 2'b00, 1'b1, 1'b0, "s0_note1");
    exp_rng(c0, 10, 11, 4'd0, 2'b00, 1'b1, 1'b0, "s0_gap");
    exp_rng(c0, 12, 15, 4'd5, 2'b10, 1'b1, 1'b0, "s0_note5");
    exp_rng(c0, 16, 16, 4'd0, 2'b10, 1'b1, 1'b0, "s0_gap2");
    exp_rng(c0, 17, 17, 4'd0, 2'b00, 1'b1, 1'b1, "s0_done");
    exp_rng(c0, 18, 20, 4'd0, 2'b00, 1'b0, 1'b0, "s0_idle");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 21);

    // stop during second PLAY
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd0;
    exp_rng(c0, 12, 13, 4'd5, 2'b10, 1'b1, 1'b0, "stop_pre");
    exp_rng(c0, 14, 22, 4'd0, 2'b00, 1'b0, 1'b0, "stop_idle");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 13);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_to(c0 + 23);

    // start and stop together in IDLE
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; stop = 1'b1; song_sel = 2'd1;
    exp_rng(c0, 1, 3, 4'd0, 2'b00, 1'b0, 1'b0, "start_stop");
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_to(c0 + 4);

    // song 1 wraps 63 -> 0; restart attempt mid-song ignored
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd1;
    exp_rng(c0, 2, 5, 4'd1, 2'b00, 1'b1, 1'b0, "s1_e0");
    exp_rng(c0, 98, 101, 4'd3, 2'b00, 1'b1, 1'b0, "s1_e16");
    exp_rng(c0, 380, 383, 4'd1, 2'b01, 1'b1, 1'b0, "s1_e63");
    exp_rng(c0, 384, 385, 4'd0, 2'b01, 1'b1, 1'b0, "s1_gap63");
    exp_rng(c0, 386, 389, 4'd1, 2'b00, 1'b1, 1'b0, "s1_wrap0");
    exp_rng(c0, 392, 395, 4'd2, 2'b01, 1'b1, 1'b0, "s1_wrap1");
    exp_rng(c0, 397, 399, 4'd0, 2'b00, 1'b0, 1'b0, "s1_stop");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 100);
    start = 1'b1; song_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 396);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_to(c0 + 400);

    // async reset mid-PLAY
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd0;
    exp_rng(c0, 2, 4, 4'd1, 2'b00, 1'b1, 1'b0, "rst_pre");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 5);
    #1 rst_n = 1'b0;
    #1 direct_idle("async_rst");
    exp_rng(c0, 7, 10, 4'd0, 2'b00, 1'b0, 1'b0, "post_rst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_to(c0 + 11);

    // 8-beat rest with reserved octave
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd2;
    exp_rng(c0, 1, 34, 4'd0, 2'b00, 1'b1, 1'b0, "s2_rest");
    exp_rng(c0, 35, 35, 4'd0, 2'b00, 1'b1, 1'b1, "s2_done");
    exp_rng(c0, 36, 37, 4'd0, 2'b00, 1'b0, 1'b0, "s2_idle");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 38);

    // audible note with reserved octave
    @(negedge clk);
    c0 = cyc;
    start = 1'b1; song_sel = 2'd3;
    exp_rng(c0, 2, 5, 4'd7, 2'b00, 1'b1, 1'b0, "s3_note7");
    exp_rng(c0, 6, 6, 4'd0, 2'b00, 1'b1, 1'b0, "s3_gap");
    exp_rng(c0, 7, 7, 4'd0, 2'b00, 1'b1, 1'b1, "s3_done");
    exp_rng(c0, 8, 9, 4'd0, 2'b00, 1'b0, 1'b0, "s3_idle");
    @(negedge clk);
    start = 1'b0;
    wait_to(c0 + 10);

    @(negedge clk);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
